byte_word_packer: RTL and testbench

- Downstream consumer of the basic byte register stage.
- Takes the registered WIDTH-bit stream and packs NUM_BYTES consecutive accepted beats into one wide word.
- Presents each word on a valid/ready output with a count of valid lanes.
- Supports an explicit flush that emits a zero-padded partial word.

---
 rtl/byte_word_packer.sv | 101 ++++++++++
 tb/tb_byte_word_packer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_word_packer.sv
// Packs NUM_BYTES accepted WIDTH-bit beats into one word on a valid/ready output,
// with an explicit flush that emits a zero-padded partial word.
module byte_word_packer #(
    parameter int WIDTH     = 8,
    parameter int NUM_BYTES = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0]                 data_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic [WIDTH*NUM_BYTES-1:0]       data_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(NUM_BYTES+1)-1:0]   out_count
);

    localparam int WORD_W = WIDTH * NUM_BYTES;
    localparam int CNT_W  = $clog2(NUM_BYTES);
    localparam int OCNT_W = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0]  LAST_LANE  = CNT_W'(NUM_BYTES - 1);
    localparam logic [OCNT_W-1:0] FULL_COUNT = OCNT_W'(NUM_BYTES);

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_data_out;
    logic              r_out_valid;
    logic [OCNT_W-1:0] r_out_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_flush_fire;
    logic              w_emit;
    logic [CNT_W-1:0]  w_lane;
    logic [OCNT_W-1:0] w_fill;
    logic [WORD_W-1:0] w_merged;

    // The output slot is free, or is being drained on this very edge.
    assign w_in_ready  = !r_out_valid || out_ready;
    assign w_accept    = in_valid && w_in_ready;
    assign w_last_beat = w_accept && (r_cnt == LAST_LANE);
    assign w_lane      = LSB_FIRST ? r_cnt : (LAST_LANE - r_cnt);
    assign w_fill      = OCNT_W'(r_cnt) + OCNT_W'(w_accept);

    // A completing word takes precedence; flush only matters for a partial word.
    assign w_flush_fire = flush && w_in_ready && (w_fill != '0) && !w_last_beat;
    assign w_emit       = w_last_beat || w_flush_fire;

    always_comb begin
        // NOTE: default assignment first so every path drives w_merged and no latch is inferred.
        w_merged = r_acc;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (w_accept && (w_lane == CNT_W'(i))) begin
                w_merged[i*WIDTH +: WIDTH] = data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_emit) begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_acc <= w_merged;
        end
    end

    // Clearing the accumulator on emit is what zero-pads the unused lanes of a flushed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_out_count <= '0;
        end else if (w_emit) begin
            r_data_out  <= w_merged;
            r_out_valid <= 1'b1;
            r_out_count <= w_last_beat ? FULL_COUNT : w_fill;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign out_count = r_out_count;

    a_count_nonzero : assert property (@(posedge clk) disable iff (rst)
        r_out_valid |-> (r_out_count != '0));
    a_cnt_in_range : assert property (@(posedge clk) disable iff (rst)
        r_cnt <= LAST_LANE);

endmodule

// File: tb/tb_byte_word_packer.sv
// Bench for byte_word_packer: one LSB-first and one MSB-first instance, with a
// queue of expected words compared whenever a word is handed off downstream.
module tb_byte_word_packer;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  data_in   = '0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic        flush     = 1'b0;
    logic [31:0] data_out;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_count;

    logic [7:0]  m_data_in   = '0;
    logic        m_in_valid  = 1'b0;
    logic        m_in_ready;
    logic        m_flush     = 1'b0;
    logic [31:0] m_data_out;
    logic        m_out_valid;
    logic        m_out_ready = 1'b1;
    logic [2:0]  m_out_count;

    exp_t q_lsb[$];
    exp_t q_msb[$];
    exp_t e_lsb;
    exp_t e_msb;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    byte_word_packer #(.WIDTH(8), .NUM_BYTES(4), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .data_out(data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
    );

    byte_word_packer #(.WIDTH(8), .NUM_BYTES(4), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .data_in(m_data_in), .in_valid(m_in_valid),
        .in_ready(m_in_ready), .flush(m_flush), .data_out(m_data_out),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_count(m_out_count)
    );

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (q_lsb.size() == 0) begin
                n_err++;
                $display("FAIL lsb_unexpected_word: got %h/%0d, expected no word", data_out, out_count);
            end else begin
                e_lsb = q_lsb.pop_front();
                if ({data_out, out_count} !== {e_lsb.data, e_lsb.count}) begin
                    n_err++;
                    $display("FAIL lsb_word: got %h/%0d, expected %h/%0d",
                             data_out, out_count, e_lsb.data, e_lsb.count);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_out_valid && m_out_ready) begin
            n_cmp++;
            if (q_msb.size() == 0) begin
                n_err++;
                $display("FAIL msb_unexpected_word: got %h/%0d, expected no word", m_data_out, m_out_count);
            end else begin
                e_msb = q_msb.pop_front();
                if ({m_data_out, m_out_count} !== {e_msb.data, e_msb.count}) begin
                    n_err++;
                    $display("FAIL msb_word: got %h/%0d, expected %h/%0d",
                             m_data_out, m_out_count, e_msb.data, e_msb.count);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        data_in  = d;
        step();
    endtask

    task automatic check_word(input string name, input logic [31:0] d, input logic [2:0] c);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, data_out, out_count} !== {1'b1, d, c}) begin
            n_err++;
            $display("FAIL %s: got v=%b %h/%0d, expected v=1 %h/%0d", name, out_valid, data_out, out_count, d, c);
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got out_valid=%b, expected 0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, data_out, out_count, in_ready} !== {1'b0, 32'h0, 3'd0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h c=%0d rdy=%b, expected v=0 d=0 c=0 rdy=1",
                     out_valid, data_out, out_count, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_pack();
        out_ready = 1'b1;
        feed(8'h05);
        feed(8'h0A);
        feed(8'h03);
        q_lsb.push_back('{data: 32'h0F030A05, count: 3'd4});
        feed(8'h0F);
        in_valid = 1'b0;
        check_word("basic_word", 32'h0F030A05, 3'd4);
        step();
        check_idle("basic_single_cycle");
    endtask

    task automatic test_lane_order();
        logic [7:0] beats [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        q_msb.push_back('{data: 32'h11223344, count: 3'd4});
        for (int i = 0; i < 4; i++) begin
            m_in_valid = 1'b1;
            m_data_in  = beats[i];
            step();
        end
        m_in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({m_out_valid, m_data_out, m_out_count} !== {1'b1, 32'h11223344, 3'd4}) begin
            n_err++;
            $display("FAIL msb_lane_order: got v=%b %h/%0d, expected v=1 11223344/4",
                     m_out_valid, m_data_out, m_out_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        feed(8'hDD);
        feed(8'hCC);
        feed(8'hBB);
        q_lsb.push_back('{data: 32'hAABBCCDD, count: 3'd4});
        feed(8'hAA);
        in_valid = 1'b1;
        data_in  = 8'h01;
        for (int k = 0; k < 3; k++) begin
            check_word("bp_hold", 32'hAABBCCDD, 3'd4);
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_in_ready_low: got %b, expected 0", in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_in_ready_high: got %b, expected 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        check_idle("bp_drained");
        feed(8'h02);
        feed(8'h03);
        q_lsb.push_back('{data: 32'h04030201, count: 3'd4});
        feed(8'h04);
        in_valid = 1'b0;
        check_word("bp_next_word", 32'h04030201, 3'd4);
        step();
    endtask

    task automatic test_partial_flush();
        feed(8'h05);
        feed(8'h0A);
        in_valid = 1'b0;
        flush    = 1'b1;
        q_lsb.push_back('{data: 32'h00000A05, count: 3'd2});
        step();
        flush = 1'b0;
        check_word("flush_partial", 32'h00000A05, 3'd2);
        feed(8'h01);
        feed(8'h02);
        feed(8'h03);
        q_lsb.push_back('{data: 32'h04030201, count: 3'd4});
        feed(8'h04);
        in_valid = 1'b0;
        check_word("flush_next_lane0", 32'h04030201, 3'd4);
        step();
    endtask

    task automatic test_flush_edges();
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        check_idle("flush_empty_noop");
        step();
        check_idle("flush_empty_still_idle");
        feed(8'h05);
        feed(8'h0A);
        feed(8'h03);
        flush = 1'b1;
        q_lsb.push_back('{data: 32'h0F030A05, count: 3'd4});
        feed(8'h0F);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_word("flush_with_last_beat", 32'h0F030A05, 3'd4);
        step();
        check_idle("flush_no_extra_word");
        step();
    endtask

    task automatic test_async_reset();
        feed(8'h01);
        feed(8'h02);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, data_out, out_count} !== {1'b0, 32'h0, 3'd0}) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h c=%0d, expected v=0 d=0 c=0",
                     out_valid, data_out, out_count);
        end
        #1 rst = 1'b0;
        step();
        feed(8'hA1);
        feed(8'hB2);
        feed(8'hC3);
        q_lsb.push_back('{data: 32'hD4C3B2A1, count: 3'd4});
        feed(8'hD4);
        in_valid = 1'b0;
        check_word("post_reset_word", 32'hD4C3B2A1, 3'd4);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_pack();
        test_lane_order();
        test_backpressure();
        test_partial_flush();
        test_flush_edges();
        test_async_reset();
        step();
        n_cmp++;
        if (q_lsb.size() + q_msb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drained: got %0d words outstanding, expected 0",
                     q_lsb.size() + q_msb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
